tilelink_ad_arbiter: RTL

Two-master to one-slave arbiter for the TileLink-UL A/D channel pair used by the formal harness around the Rocket tile. It shares a single downstream A/D port (memory model or dummy slave) between two upstream masters, for example a tile master port and a harness-side test master. It grants round-robin, keeps one transaction outstanding, and routes each D-channel response, single- or multi-beat, back to the master that issued the request. A sticky protocol-error flag reports D responses that arrive with no request outstanding.

---
 rtl/tilelink_ad_arbiter_if.sv | 40 ++++
 rtl/tilelink_ad_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/tilelink_ad_arbiter_if.sv
// One TileLink-UL A/D link. The master modport issues A requests and takes D
// responses; the slave modport is the side that accepts A and returns D.
interface tilelink_ad_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  a_valid;
   logic                  a_ready;
   logic [2:0]            a_bits_opcode;
   logic [2:0]            a_bits_param;
   logic [3:0]            a_bits_size;
   logic                  a_bits_source;
   logic [ADDR_W-1:0]     a_bits_address;
   logic [DATA_W/8-1:0]   a_bits_mask;
   logic [DATA_W-1:0]     a_bits_data;

   logic                  d_valid;
   logic                  d_ready;
   logic [2:0]            d_bits_opcode;
   logic [1:0]            d_bits_param;
   logic [3:0]            d_bits_size;
   logic                  d_bits_source;
   logic                  d_bits_sink;
   logic [DATA_W-1:0]     d_bits_data;
   logic                  d_bits_error;

   modport master (
      output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
             a_bits_address, a_bits_mask, a_bits_data, d_ready,
      input  a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size,
             d_bits_source, d_bits_sink, d_bits_data, d_bits_error
   );

   modport slave (
      input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
             a_bits_address, a_bits_mask, a_bits_data, d_ready,
      output a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size,
             d_bits_source, d_bits_sink, d_bits_data, d_bits_error
   );
endinterface

// File: rtl/tilelink_ad_arbiter.sv
// Round-robin 2:1 TileLink-UL A/D arbiter, one transaction outstanding, zero-latency A and D paths.
// A backpressure comes straight from s_a_ready; D backpressure from the owning master's d_ready.
module tilelink_ad_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   tilelink_ad_arbiter_if.slave  m0,
   tilelink_ad_arbiter_if.slave  m1,
   tilelink_ad_arbiter_if.master s,
   output logic                  err_unexpected_d,
   output logic                  grant_owner
);
   localparam int BEAT_LG = $clog2(DATA_W / 8);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state_q;
   logic                prio_q;
   logic                owner_q;
   logic                err_q;
   logic                lock_q;
   logic                lock_sel_q;
   logic [2:0]          op_opcode_q;
   logic [3:0]          op_size_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                gnt_vld;
   logic                gnt_sel;
   logic                a_vld;
   logic                a_hs;
   logic                busy;
   logic                d_hs;
   logic                last_beat;
   logic [CNT_W-1:0]    beats;
   logic [2:0]          sel_opcode;
   logic [3:0]          sel_size;
   logic [ADDR_W-1:0]   sel_addr;

   // A stalled winner keeps the grant until its handshake, even if prio would pick the other side.
   always_comb begin
      gnt_vld = m0.a_valid | m1.a_valid;
      gnt_sel = 1'b0;
      if (lock_q && (lock_sel_q ? m1.a_valid : m0.a_valid))
         gnt_sel = lock_sel_q;
      else if (m0.a_valid && m1.a_valid)
         gnt_sel = prio_q;
      else
         gnt_sel = m1.a_valid;
   end

   assign sel_opcode = gnt_sel ? m1.a_bits_opcode  : m0.a_bits_opcode;
   assign sel_size   = gnt_sel ? m1.a_bits_size    : m0.a_bits_size;
   assign sel_addr   = gnt_sel ? m1.a_bits_address : m0.a_bits_address;

   assign a_vld = !reset && (state_q == IDLE) && gnt_vld;
   assign a_hs  = a_vld && s.a_ready;

   assign s.a_valid        = a_vld;
   assign s.a_bits_opcode  = sel_opcode;
   assign s.a_bits_param   = gnt_sel ? m1.a_bits_param  : m0.a_bits_param;
   assign s.a_bits_size    = sel_size;
   assign s.a_bits_source  = gnt_sel ? m1.a_bits_source : m0.a_bits_source;
   assign s.a_bits_address = sel_addr;
   assign s.a_bits_mask    = gnt_sel ? m1.a_bits_mask   : m0.a_bits_mask;
   assign s.a_bits_data    = gnt_sel ? m1.a_bits_data   : m0.a_bits_data;

   assign m0.a_ready = a_vld && !gnt_sel && s.a_ready;
   assign m1.a_ready = a_vld &&  gnt_sel && s.a_ready;

   // In IDLE the downstream D port is always drained so stray beats cannot wedge the slave.
   assign busy      = !reset && (state_q == BUSY);
   assign m0.d_valid = busy && !owner_q && s.d_valid;
   assign m1.d_valid = busy &&  owner_q && s.d_valid;
   assign s.d_ready = !reset && ((state_q == IDLE) || (owner_q ? m1.d_ready : m0.d_ready));
   assign d_hs      = busy && s.d_valid && s.d_ready;

   assign m0.d_bits_opcode = s.d_bits_opcode;
   assign m0.d_bits_param  = s.d_bits_param;
   assign m0.d_bits_size   = s.d_bits_size;
   assign m0.d_bits_source = s.d_bits_source;
   assign m0.d_bits_sink   = s.d_bits_sink;
   assign m0.d_bits_data   = s.d_bits_data;
   assign m0.d_bits_error  = s.d_bits_error;
   assign m1.d_bits_opcode = s.d_bits_opcode;
   assign m1.d_bits_param  = s.d_bits_param;
   assign m1.d_bits_size   = s.d_bits_size;
   assign m1.d_bits_source = s.d_bits_source;
   assign m1.d_bits_sink   = s.d_bits_sink;
   assign m1.d_bits_data   = s.d_bits_data;
   assign m1.d_bits_error  = s.d_bits_error;

   // Get, ArithmeticData and LogicalData return data beats; everything else is a single ack.
   always_comb begin
      beats = CNT_W'(1);
      if ((op_opcode_q == 3'd4 || op_opcode_q == 3'd2 || op_opcode_q == 3'd3) &&
          (op_size_q > 4'(BEAT_LG)))
         beats = CNT_W'(1) << (op_size_q - 4'(BEAT_LG));
   end

   assign last_beat = (cnt_q + CNT_W'(1)) == beats;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         owner_q     <= 1'b0;
         err_q       <= 1'b0;
         lock_q      <= 1'b0;
         lock_sel_q  <= 1'b0;
         op_opcode_q <= 3'd0;
         op_size_q   <= 4'd0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (s.d_valid)
                  err_q <= 1'b1;
               if (a_hs) begin
                  state_q     <= BUSY;
                  owner_q     <= gnt_sel;
                  prio_q      <= ~gnt_sel;
                  op_opcode_q <= sel_opcode;
                  op_size_q   <= sel_size;
                  cnt_q       <= '0;
                  lock_q      <= 1'b0;
               end else begin
                  lock_q     <= a_vld;
                  lock_sel_q <= gnt_sel;
               end
            end
            BUSY: begin
               if (d_hs) begin
                  if (last_beat)
                     state_q <= IDLE;
                  else
                     cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign err_unexpected_d = !reset && err_q;
   assign grant_owner      = !reset && owner_q;

endmodule
